// File: rtl/vga_text_pkg.sv
// Shared constants, types and helpers for the text-mode pixel pipeline.
package vga_text_pkg;

    localparam int unsigned GLYPH_W      = 8;
    localparam int unsigned GLYPH_H      = 16;
    localparam int unsigned GLYPH_ADDR_W = 14;
    localparam int unsigned TEXT_ADDR_W  = 12;
    localparam int unsigned LATENCY      = 5;

    typedef logic [7:0] rgb332_t;

    // Per-pixel side information that travels alongside the memory reads.
    typedef struct packed {
        logic                         de;
        logic                         hs;
        logic                         vs;
        logic                         in_range;
        logic [$clog2(GLYPH_W)-1:0]   xcol;
        logic [$clog2(GLYPH_H)-1:0]   yrow;
        logic                         cur;
    } sideband_t;

    localparam int unsigned SB_W = $bits(sideband_t);

    function automatic logic [GLYPH_ADDR_W-1:0] pack_glyph_addr(
        input logic [6:0]                 code,
        input logic [$clog2(GLYPH_H)-1:0] yrow,
        input logic [$clog2(GLYPH_W)-1:0] xcol
    );
        return {code, yrow, xcol};
    endfunction

endpackage

// File: rtl/vga_sideband_delay.sv
// Fixed-depth shift register for pixel sideband bits; syncs reset to their idle level.
module vga_sideband_delay
    import vga_text_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter logic        SYNC_IDLE = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SB_W-1:0] i_sb,
    output logic [SB_W-1:0] o_sb
);

    localparam sideband_t SB_RST = '{
        de:       1'b0,
        hs:       SYNC_IDLE,
        vs:       SYNC_IDLE,
        in_range: 1'b0,
        xcol:     '0,
        yrow:     '0,
        cur:      1'b0
    };

    logic [SB_W-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_stage[i] <= SB_RST;
            end
        end else begin
            r_stage[0] <= i_sb;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_sb = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_text_renderer.sv
// Text-mode renderer: pixel -> char buffer -> glyph ROM -> RGB332, five-cycle pipeline.
// Optional blinking cursor is built when VGA_TEXT_CURSOR_EN is defined.
module vga_text_renderer
    import vga_text_pkg::*;
#(
    parameter int unsigned COLS       = 80,
    parameter int unsigned ROWS       = 30,
    parameter logic [7:0]  FG_COLOR   = 8'hFF,
    parameter logic [7:0]  BG_COLOR   = 8'h00,
    parameter logic        SYNC_IDLE  = 1'b1,
    parameter int unsigned BLINK_LOG2 = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  i_x,
    input  logic [9:0]  i_y,
    input  logic        i_de_in,
    input  logic        i_hsync_in,
    input  logic        i_vsync_in,
    output logic [11:0] o_text_addr,
    input  logic [7:0]  i_text_data,
    output logic [13:0] o_glyph_addr,
    input  logic        i_glyph_bit,
    input  logic [6:0]  i_cursor_col,
    input  logic [4:0]  i_cursor_row,
    output logic [7:0]  o_rgb,
    output logic        o_de_out,
    output logic        o_hsync_out,
    output logic        o_vsync_out
);

    logic [6:0]             w_col;
    logic [5:0]             w_row;
    logic                   w_in_range;
    logic                   w_cur;
    logic [TEXT_ADDR_W-1:0] w_row_ext;
    logic [TEXT_ADDR_W-1:0] w_text_addr;
    sideband_t              w_sb_s1;
    sideband_t              w_sb_s2;
    sideband_t              w_sb_s4;
    logic                   w_cursor_hit;
    logic                   w_pix;
    logic                   w_unused;

    logic [TEXT_ADDR_W-1:0]  r_text_addr;
    logic [GLYPH_ADDR_W-1:0] r_glyph_addr;
    logic                    r_inv;
    logic                    r_inv_s4;
    rgb332_t                 r_rgb;
    logic                    r_de;
    logic                    r_hs;
    logic                    r_vs;

    assign w_col       = i_x[9:3];
    assign w_row       = i_y[9:4];
    assign w_in_range  = (32'(w_col) < COLS) && (32'(w_row) < ROWS);
    assign w_row_ext   = TEXT_ADDR_W'(w_row);
    // Out-of-range cells still produce an address; it simply wraps in 12 bits.
    assign w_text_addr = w_row_ext * TEXT_ADDR_W'(COLS) + TEXT_ADDR_W'(w_col);

`ifdef VGA_TEXT_CURSOR_EN
    logic [BLINK_LOG2:0] r_frame;
    logic                r_vs_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame   <= '0;
            r_vs_prev <= SYNC_IDLE;
        end else begin
            r_vs_prev <= i_vsync_in;
            if ((r_vs_prev == SYNC_IDLE) && (i_vsync_in != SYNC_IDLE)) begin
                r_frame <= r_frame + 1'b1;
            end
        end
    end

    assign w_cur        = (w_col == i_cursor_col) && (w_row == {1'b0, i_cursor_row});
    assign w_cursor_hit = w_sb_s4.cur && (w_sb_s4.yrow >= 4'd14) && r_frame[BLINK_LOG2];
    assign w_unused     = ^{w_sb_s4.xcol};
`else
    assign w_cur        = 1'b0;
    assign w_cursor_hit = 1'b0;
    assign w_unused     = ^{i_cursor_col, i_cursor_row, w_sb_s4.xcol, w_sb_s4.yrow,
                            w_sb_s4.cur, BLINK_LOG2[0]};
`endif

    always_comb begin
        w_sb_s1          = '0;
        w_sb_s1.de       = i_de_in;
        w_sb_s1.hs       = i_hsync_in;
        w_sb_s1.vs       = i_vsync_in;
        w_sb_s1.in_range = w_in_range;
        w_sb_s1.xcol     = i_x[2:0];
        w_sb_s1.yrow     = i_y[3:0];
        w_sb_s1.cur      = w_cur;
    end

    // S1..S2: sideband waits for the character buffer read.
    vga_sideband_delay #(
        .DEPTH     (2),
        .SYNC_IDLE (SYNC_IDLE)
    ) u_delay_text (
        .clk   (clk),
        .rst_n (rst_n),
        .i_sb  (w_sb_s1),
        .o_sb  (w_sb_s2)
    );

    // S3..S4: sideband waits for the glyph ROM read.
    vga_sideband_delay #(
        .DEPTH     (LATENCY - 3),
        .SYNC_IDLE (SYNC_IDLE)
    ) u_delay_glyph (
        .clk   (clk),
        .rst_n (rst_n),
        .i_sb  (w_sb_s2),
        .o_sb  (w_sb_s4)
    );

    assign w_pix = i_glyph_bit ^ r_inv_s4 ^ w_cursor_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_text_addr  <= '0;
            r_glyph_addr <= '0;
            r_inv        <= 1'b0;
            r_inv_s4     <= 1'b0;
            r_rgb        <= '0;
            r_de         <= 1'b0;
            r_hs         <= SYNC_IDLE;
            r_vs         <= SYNC_IDLE;
        end else begin
            r_text_addr  <= w_text_addr;
            r_glyph_addr <= pack_glyph_addr(i_text_data[6:0], w_sb_s2.yrow, w_sb_s2.xcol);
            r_inv        <= i_text_data[7];
            r_inv_s4     <= r_inv;
            r_rgb        <= (w_sb_s4.de && w_sb_s4.in_range) ? (w_pix ? FG_COLOR : BG_COLOR)
                                                             : '0;
            r_de         <= w_sb_s4.de;
            r_hs         <= w_sb_s4.hs;
            r_vs         <= w_sb_s4.vs;
        end
    end

    assign o_text_addr  = r_text_addr;
    assign o_glyph_addr = r_glyph_addr;
    assign o_rgb        = r_rgb;
    assign o_de_out     = r_de;
    assign o_hsync_out  = r_hs;
    assign o_vsync_out  = r_vs;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Self-checking bench for vga_text_renderer with behavioural char-buffer/ROM models.
module tb_vga_text_renderer;

`ifdef VGA_TEXT_CURSOR_EN
    localparam bit CursorEn = 1'b1;
`else
    localparam bit CursorEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  x, y;
    logic        de_in, hsync_in, vsync_in;
    logic [11:0] text_addr;
    logic [7:0]  text_data;
    logic [13:0] glyph_addr;
    logic        glyph_bit;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [7:0]  rgb;
    logic        de_out, hsync_out, vsync_out;

    logic [7:0] text_mem [0:4095];
    logic       glyph_rom [0:16383];

    int n_checks = 0;
    int n_pass   = 0;
    int tb_frames = 0;

    always #5 clk = ~clk;

    vga_text_renderer #(
        .BLINK_LOG2 (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_x          (x),
        .i_y          (y),
        .i_de_in      (de_in),
        .i_hsync_in   (hsync_in),
        .i_vsync_in   (vsync_in),
        .o_text_addr  (text_addr),
        .i_text_data  (text_data),
        .o_glyph_addr (glyph_addr),
        .i_glyph_bit  (glyph_bit),
        .i_cursor_col (cursor_col),
        .i_cursor_row (cursor_row),
        .o_rgb        (rgb),
        .o_de_out     (de_out),
        .o_hsync_out  (hsync_out),
        .o_vsync_out  (vsync_out)
    );

    // One-cycle synchronous memories.
    always @(posedge clk) begin
        text_data <= text_mem[text_addr];
        glyph_bit <= glyph_rom[glyph_addr];
    end

    // Reference pixel colour from the text-mode rules, evaluated on the current memories.
    function automatic logic [7:0] exp_rgb(input int px, input int py, input bit de);
        int col, row, code;
        bit pix, hit;
        col = px / 8;
        row = py / 16;
        if (!de || col >= 80 || row >= 30) return 8'h00;
        code = int'(text_mem[row * 80 + col]);
        pix  = glyph_rom[(code % 128) * 128 + (py % 16) * 8 + (px % 8)];
        hit  = CursorEn && (col == int'(cursor_col)) && (row == int'(cursor_row)) &&
               ((py % 16) >= 14) && (((tb_frames / 2) % 2) == 1);
        pix  = pix ^ (code >= 128) ^ hit;
        return pix ? 8'hFF : 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int px, input int py, input bit de, input bit hs, input bit vs);
        x        = 10'(px);
        y        = 10'(py);
        de_in    = de;
        hsync_in = hs;
        vsync_in = vs;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Presents one pixel, then idles until it has reached the outputs.
    task automatic run_pixel(input int px, input int py, input bit de);
        idle(5);
        drive(px, py, de, 1'b1, 1'b1);
        tick();
        idle(4);
    endtask

    task automatic vsync_pulse();
        drive(0, 0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        idle(3);
        tb_frames++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        tb_frames = 0;
    endtask

    task automatic test_reset();
        text_mem[162] = 8'h41;
        glyph_rom[14'h2099] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b1,
                  1'($urandom), 1'b1);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (rgb !== 8'h00) $display("FAIL reset_rgb: got %h want 00", rgb); else n_pass++;
        n_checks++; if (de_out !== 1'b0) $display("FAIL reset_de: got %b want 0", de_out); else n_pass++;
        n_checks++;
        if (hsync_out !== 1'b1 || vsync_out !== 1'b1)
            $display("FAIL reset_sync: got hs=%b vs=%b want 1 1", hsync_out, vsync_out);
        else n_pass++;
        n_checks++;
        if (text_addr !== 12'd0) $display("FAIL reset_taddr: got %0d want 0", text_addr);
        else n_pass++;
        n_checks++;
        if (glyph_addr !== 14'd0) $display("FAIL reset_gaddr: got %h want 0", glyph_addr);
        else n_pass++;
        drive(17, 35, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (rgb !== 8'h00 || de_out !== 1'b0 || hsync_out !== 1'b1)
            $display("FAIL reset_hold: got rgb=%h de=%b hs=%b want 00 0 1", rgb, de_out, hsync_out);
        else n_pass++;
        drive(0, 0, 1'b0, 1'b1, 1'b1);
        tick();
        rst_n = 1'b1;
        drive(17, 35, 1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            drive(0, 0, 1'b0, 1'b1, 1'b1);
            if (k < 5) begin
                n_checks++;
                if (de_out !== 1'b0) $display("FAIL release_early k=%0d: de=%b want 0", k, de_out);
                else n_pass++;
            end
        end
        n_checks++;
        if (de_out !== 1'b1 || rgb !== 8'hFF)
            $display("FAIL release_first: got de=%b rgb=%h want 1 FF", de_out, rgb);
        else n_pass++;
    endtask

    task automatic test_addr_gen();
        text_mem[162] = 8'h41;
        idle(5);
        drive(17, 35, 1'b1, 1'b1, 1'b1);
        tick();
        n_checks++;
        if (text_addr !== 12'(2 * 80 + 2)) $display("FAIL text_addr: got %0d want 162", text_addr);
        else n_pass++;
        drive(0, 0, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        n_checks++;
        if (glyph_addr !== 14'(8'h41 * 128 + 3 * 8 + 1))
            $display("FAIL glyph_addr: got %h want 2099", glyph_addr);
        else n_pass++;
    endtask

    task automatic test_pixel_latency();
        logic [7:0] codes [2];
        logic [7:0] want  [2];
        codes[0] = 8'h41; want[0] = 8'hFF;
        codes[1] = 8'hC1; want[1] = 8'h00;
        glyph_rom[14'h2099] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            text_mem[162] = codes[c];
            idle(5);
            drive(17, 35, 1'b1, 1'b1, 1'b1);
            for (int k = 1; k <= 5; k++) begin
                tick();
                drive(0, 0, 1'b0, 1'b1, 1'b1);
                if (k < 5) begin
                    n_checks++;
                    if (de_out !== 1'b0) $display("FAIL latency_early k=%0d: de=%b want 0", k, de_out);
                    else n_pass++;
                end
            end
            n_checks++;
            if (rgb !== want[c] || de_out !== 1'b1)
                $display("FAIL pixel code=%h: got rgb=%h de=%b want %h 1", codes[c], rgb, de_out,
                         want[c]);
            else n_pass++;
        end
    endtask

    task automatic test_blanking();
        text_mem[12] = 8'h41;
        glyph_rom[8'h41 * 128 + 0 * 8 + 4] = 1'b1;
        run_pixel(100, 0, 1'b0);
        n_checks++;
        if (rgb !== 8'h00 || de_out !== 1'b0)
            $display("FAIL blank_de: got rgb=%h de=%b want 00 0", rgb, de_out);
        else n_pass++;
        text_mem[80] = 8'h41;
        glyph_rom[8'h41 * 128 + 10 * 8 + 5] = 1'b1;
        run_pixel(645, 10, 1'b1);
        n_checks++;
        if (rgb !== 8'h00 || de_out !== 1'b1)
            $display("FAIL blank_range: got rgb=%h de=%b want 00 1", rgb, de_out);
        else n_pass++;
        idle(5);
        drive(0, 0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            drive(0, 0, 1'b0, 1'b1, 1'b1);
            n_checks++;
            if (hsync_out !== ((k == 5) ? 1'b0 : 1'b1))
                $display("FAIL hsync_delay k=%0d: got %b want %b", k, hsync_out, (k == 5) ? 1'b0 : 1'b1);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int k;
        text_mem[0] = 8'h41;
        text_mem[1] = 8'h42;
        for (int i = 0; i < 16 * 128; i++) glyph_rom[8'h41 * 128 + i] = 1'($urandom);
        idle(5);
        for (int c = 0; c < 21; c++) begin
            if (c < 16) drive(c, 0, 1'b1, 1'b1, 1'b1);
            else drive(0, 0, 1'b0, 1'b1, 1'b1);
            tick();
            k = c - 2;
            if (k >= 0 && k < 16) begin
                n_checks++;
                if (glyph_addr !== 14'(((k < 8) ? 8'h41 : 8'h42) * 128 + (k % 8)))
                    $display("FAIL b2b_gaddr x=%0d: got %h want %h", k, glyph_addr,
                             14'(((k < 8) ? 8'h41 : 8'h42) * 128 + (k % 8)));
                else n_pass++;
            end
            k = c - 4;
            if (k >= 0 && k < 16) begin
                n_checks++;
                if (rgb !== exp_rgb(k, 0, 1'b1) || de_out !== 1'b1)
                    $display("FAIL b2b_rgb x=%0d: got rgb=%h de=%b want %h 1", k, rgb, de_out,
                             exp_rgb(k, 0, 1'b1));
                else n_pass++;
            end
        end
    endtask

    task automatic test_cursor();
        do_reset();
        cursor_col = 7'd2;
        cursor_row = 5'd2;
        text_mem[162] = 8'h41;
        glyph_rom[8'h41 * 128 + 14 * 8] = 1'b0;
        glyph_rom[8'h41 * 128 + 13 * 8] = 1'b0;
        vsync_pulse();
        vsync_pulse();
        run_pixel(16, 46, 1'b1);
        n_checks++;
        if (rgb !== exp_rgb(16, 46, 1'b1))
            $display("FAIL cursor_on: got %h want %h", rgb, exp_rgb(16, 46, 1'b1));
        else n_pass++;
        run_pixel(16, 45, 1'b1);
        n_checks++;
        if (rgb !== 8'h00) $display("FAIL cursor_yrow13: got %h want 00", rgb);
        else n_pass++;
        vsync_pulse();
        vsync_pulse();
        run_pixel(16, 46, 1'b1);
        n_checks++;
        if (rgb !== 8'h00) $display("FAIL cursor_off: got %h want 00", rgb);
        else n_pass++;
    endtask

    task automatic test_random_pixels();
        logic [7:0] q_rgb [$];
        bit         q_de  [$];
        bit         q_hs  [$];
        int px, py;
        bit de, hs;
        for (int i = 0; i < 4096; i++) text_mem[i] = 8'($urandom);
        for (int i = 0; i < 16384; i++) glyph_rom[i] = 1'($urandom);
        cursor_col = 7'($urandom_range(0, 79));
        cursor_row = 5'($urandom_range(0, 29));
        if (((tb_frames / 2) % 2) == 0) begin
            vsync_pulse();
            vsync_pulse();
        end
        idle(5);
        for (int i = 0; i < 405; i++) begin
            if (i >= 400) begin
                px = 0; py = 0; de = 1'b0; hs = 1'b1;
            end else if ((i % 8) == 0) begin
                px = int'(cursor_col) * 8 + int'($urandom_range(0, 7));
                py = int'(cursor_row) * 16 + int'($urandom_range(12, 15));
                de = 1'b1; hs = 1'($urandom);
            end else begin
                px = int'($urandom_range(0, 799));
                py = int'($urandom_range(0, 524));
                de = 1'($urandom); hs = 1'($urandom);
            end
            drive(px, py, de, hs, 1'b1);
            q_rgb.push_back(exp_rgb(px, py, de));
            q_de.push_back(de);
            q_hs.push_back(hs);
            tick();
            if (q_rgb.size() == 5) begin
                logic [7:0] e_rgb;
                bit e_de, e_hs;
                e_rgb = q_rgb.pop_front();
                e_de  = q_de.pop_front();
                e_hs  = q_hs.pop_front();
                n_checks++;
                if (rgb !== e_rgb || de_out !== e_de || hsync_out !== e_hs || vsync_out !== 1'b1)
                    $display("FAIL random #%0d: got rgb=%h de=%b hs=%b vs=%b want %h %b %b 1",
                             i - 4, rgb, de_out, hsync_out, vsync_out, e_rgb, e_de, e_hs);
                else n_pass++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) text_mem[i] = 8'h00;
        for (int i = 0; i < 16384; i++) glyph_rom[i] = 1'b0;
        cursor_col = 7'd0;
        cursor_row = 5'd0;
        drive(0, 0, 1'b0, 1'b1, 1'b1);
        do_reset();
        test_reset();
        test_addr_gen();
        test_pixel_latency();
        test_blanking();
        test_back_to_back();
        test_cursor();
        test_random_pixels();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
